spi_master_core: RTL and testbench
==================================

# spi_master_core

Parameterised SPI master engine with CPOL/CPHA mode select, programmable SCLK divider, per-transfer slave-select addressing and continuous (back-to-back) mode. It sits under the CPU-facing SPI register block, which drives its control inputs from register bits. The engine shifts `D_WIDTH` bits MSB-first on `mosi` and captures the same number from `miso` into `rx_data`.

## Interface
- `SLAVES`, default 1: number of slave-select lines.
- `D_WIDTH`, default 8: bits per transfer.
- `clock` in 1: system clock; all logic is clocked on the rising edge.
- `reset_n` in 1: asynchronous, active-high reset (`1` = reset); the port keeps the codebase name.
- `enable` in 1: starts a transfer when sampled high while idle.
- `cpol` in 1: SCLK idle level.
- `cpha` in 1: 0 = sample on the first SCLK edge; 1 = shift on the first edge, sample on the second.
- `cont` in 1: continuous mode; chains the next word without releasing `ss_n`.
- `clk_div` in 32: half-period of SCLK in `clock` cycles; 0 is treated as 1.
- `addr` in 32: slave index; any value ≥ `SLAVES` selects slave 0.
- `tx_data` in `D_WIDTH`: word to transmit, latched at start and at each continuous reload.
- `miso` in 1: serial input.
- `sclk` out 1: serial clock.
- `ss_n` out `SLAVES`: active-low slave selects.
- `mosi` out 1: serial output; high-Z when idle.
- `busy` out 1: transfer in progress.
- `rx_data` out `D_WIDTH`: last received word.

## Operation
- FSM states: READY and EXECUTE.
- Reset values:
  - `busy` = 1, `ss_n` = all 1, `mosi` = Z, `rx_data` = 0, `sclk` = 0.
  - State = READY, all internal counters cleared.
- READY:
  - Drive `busy` = 0, `ss_n` all 1, `mosi` = Z.
  - On `enable` = 1:
    - Latch slave = `addr` (or 0 if out of range).
    - Set `clk_ratio` = `count` = max(`clk_div`, 1).
    - Set `sclk` = `cpol`; `assert_data` = !`cpha`.
    - Latch `tx_buf` = `tx_data`; set `toggles` = 0; `last_rx` = 2·`D_WIDTH` + `cpha` − 1.
    - Set `busy` = 1 and go to EXECUTE.
- EXECUTE, every cycle: `busy` = 1 and `ss_n[slave]` = 0.
- EXECUTE, when `count` == `clk_ratio` (an "SCLK tick"); all of the following are evaluated with pre-tick values:
  - Set `count` = 1 and invert `assert_data`.
  - `toggles` increments, wrapping to 0 after 2·`D_WIDTH`+1.
  - If `toggles` ≤ 2·`D_WIDTH` and `ss_n[slave]` = 0: invert `sclk`.
  - Receive: if `assert_data` = 0, `toggles` < `last_rx`+1 and `ss_n[slave]` = 0, then `rx_buf` = {`rx_buf`[D_WIDTH-2:0], `miso`}.
  - Transmit: if `assert_data` = 1 and `toggles` < `last_rx`, then `mosi` = `tx_buf` MSB and `tx_buf` shifts left by one.
  - Continuous reload: if `toggles` == `last_rx` and `cont` = 1, then:
    - `tx_buf` = `tx_data`; `toggles` = `last_rx` − 2·`D_WIDTH` + 1; `continue` = 1.
  - If `continue` = 1: clear it, pulse `busy` = 0 for that cycle, and set `rx_data` = `rx_buf`.
  - End of transfer: if `toggles` == 2·`D_WIDTH`+1 and `cont` = 0:
    - `busy` = 0, `ss_n` all 1, `mosi` = Z, `rx_data` = `rx_buf`.
    - Return to READY.
- EXECUTE, otherwise: `count` increments.
- `enable` is ignored while in EXECUTE.
- `cpol`, `cpha` and `clk_div` are sampled only at start.
- `cont` is sampled live.

## Timing
- One SCLK half-period = `clk_ratio` clocks; full period = 2·max(`clk_div`,1) clocks.
- `ss_n` asserts one clock after `enable` is sampled.
- With `clk_div` = 0, the first tick occurs on the next clock.
- A transfer produces exactly 2·`D_WIDTH` SCLK edges; `sclk` ends at `cpol`.
- CPHA=0:
  - First MOSI bit is valid from the first tick, before the first SCLK edge.
  - Sampling happens on the odd edges.
- CPHA=1: shift on the odd edges, sample on the even edges.
- `rx_data` updates on the same clock that `busy` falls.
- `busy` is low again for at most one clock before a new `enable` is accepted.
- Continuous mode: `busy` drops for exactly one clock per completed word, `ss_n` stays low, and the next word starts without an idle gap.
- Reset mid-transfer immediately forces the reset values; the partial word is discarded.

## Test plan
- Mode 0, `clk_div`=0, `tx_data`=0xA5, `miso` looped to `mosi`:
  - `busy` high for about 2·8+2 clocks.
  - 16 SCLK edges; `rx_data` = 0xA5; `ss_n` = 1 after completion.
- Mode 3 (`cpol`=1, `cpha`=1), `clk_div`=4, `tx_data`=0x3C, `miso` held 1:
  - SCLK idles high with a 4-clock half-period.
  - `mosi` sequence is 0,0,1,1,1,1,0,0; `rx_data` = 0xFF.
- `SLAVES`=4:
  - `addr`=2 → only `ss_n[2]` goes low.
  - `addr`=7 → `ss_n[0]` goes low.
- `cont`=1 for two words, 0x12 then 0x34, with loopback:
  - One-clock `busy` low pulse with `rx_data` = 0x12.
  - `ss_n` stays low; final `rx_data` = 0x34.
- Assert reset mid-transfer at bit 4:
  - `busy` = 1, `ss_n` = all 1, `mosi` = Z, `rx_data` = 0.
  - After release, `busy` = 0 on the next clock.
- `enable` pulsed during EXECUTE: ignored; the transfer completes unaltered.

Source files
------------

// File: rtl/spi_master_core.sv
// SPI master engine: CPOL/CPHA modes, programmable SCLK half-period, per-transfer
// slave select and continuous (back-to-back) words without releasing ss_n.
//
// state   | meaning
// READY   | idle, ss_n released, mosi tri-stated; waits for enable
// EXECUTE | shifting a word; one SCLK half-period per tick of the divider
module spi_master_core #(
  parameter int SLAVES  = 1,
  parameter int D_WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cpol,
  input  logic               cpha,
  input  logic               cont,
  input  logic [31:0]        clk_div,
  input  logic [31:0]        addr,
  input  logic [D_WIDTH-1:0] tx_data,
  input  logic               miso,
  output logic               sclk,
  output logic [SLAVES-1:0]  ss_n,
  output logic               mosi,
  output logic               busy,
  output logic [D_WIDTH-1:0] rx_data
);

  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int TW = $clog2(2 * D_WIDTH + 2);
  localparam logic [TW-1:0] T_ONE       = TW'(1);
  localparam logic [TW-1:0] T_LAST_EDGE = TW'(2 * D_WIDTH);
  localparam logic [TW-1:0] T_END       = TW'(2 * D_WIDTH + 1);

  typedef enum logic {READY, EXECUTE} state_t;

  state_t              state, state_nxt;
  logic [SW-1:0]       slave, slave_nxt;
  logic [31:0]         clk_ratio, clk_ratio_nxt;
  logic [31:0]         count, count_nxt;
  logic                assert_data, assert_data_nxt;
  logic [D_WIDTH-1:0]  tx_buf, tx_buf_nxt;
  logic [D_WIDTH-1:0]  rx_buf, rx_buf_nxt;
  logic [TW-1:0]       toggles, toggles_nxt;
  logic [TW-1:0]       last_rx, last_rx_nxt;
  logic                cont_pend, cont_pend_nxt;
  logic                sclk_nxt, busy_nxt, mosi_q, mosi_q_nxt, mosi_oe, mosi_oe_nxt;
  logic [SLAVES-1:0]   ss_n_nxt;
  logic [D_WIDTH-1:0]  rx_data_nxt;
  logic [SLAVES-1:0]   sel_mask;
  logic                sel_active;
  logic                tick;

  assign tick       = (count == clk_ratio);
  assign sel_mask   = SLAVES'(1) << slave;
  assign sel_active = ~|(ss_n & sel_mask);
  assign mosi       = mosi_oe ? mosi_q : 1'bz;

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) state <= READY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      READY:   if (enable) state_nxt = EXECUTE;
      EXECUTE: if (tick && toggles == T_END && !cont) state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  // Next values for the datapath and the registered outputs; every tick
  // decision uses the pre-tick register values.
  always_comb begin
    slave_nxt       = slave;
    clk_ratio_nxt   = clk_ratio;
    count_nxt       = count;
    assert_data_nxt = assert_data;
    tx_buf_nxt      = tx_buf;
    rx_buf_nxt      = rx_buf;
    toggles_nxt     = toggles;
    last_rx_nxt     = last_rx;
    cont_pend_nxt   = cont_pend;
    sclk_nxt        = sclk;
    busy_nxt        = busy;
    ss_n_nxt        = ss_n;
    mosi_q_nxt      = mosi_q;
    mosi_oe_nxt     = mosi_oe;
    rx_data_nxt     = rx_data;
    case (state)
      READY: begin
        busy_nxt      = 1'b0;
        ss_n_nxt      = '1;
        mosi_oe_nxt   = 1'b0;
        cont_pend_nxt = 1'b0;
        if (enable) begin
          busy_nxt        = 1'b1;
          slave_nxt       = (addr < 32'(SLAVES)) ? SW'(addr) : '0;
          clk_ratio_nxt   = (clk_div == 32'd0) ? 32'd1 : clk_div;
          count_nxt       = (clk_div == 32'd0) ? 32'd1 : clk_div;
          sclk_nxt        = cpol;
          assert_data_nxt = ~cpha;
          tx_buf_nxt      = tx_data;
          toggles_nxt     = '0;
          last_rx_nxt     = TW'(2 * D_WIDTH - 1) + TW'(cpha);
        end
      end
      EXECUTE: begin
        busy_nxt = 1'b1;
        ss_n_nxt = ss_n & ~sel_mask;
        if (tick) begin
          count_nxt       = 32'd1;
          assert_data_nxt = ~assert_data;
          toggles_nxt     = (toggles == T_END) ? '0 : toggles + T_ONE;
          if (toggles <= T_LAST_EDGE && sel_active)
            sclk_nxt = ~sclk;
          if (!assert_data && toggles < last_rx + T_ONE && sel_active)
            rx_buf_nxt = {rx_buf[D_WIDTH-2:0], miso};
          if (assert_data && toggles < last_rx) begin
            mosi_q_nxt  = tx_buf[D_WIDTH-1];
            mosi_oe_nxt = 1'b1;
            tx_buf_nxt  = tx_buf << 1;
          end
          if (toggles == last_rx && cont) begin
            tx_buf_nxt    = tx_data;
            toggles_nxt   = last_rx - T_LAST_EDGE + T_ONE;
            cont_pend_nxt = 1'b1;
          end
          if (cont_pend) begin
            cont_pend_nxt = 1'b0;
            busy_nxt      = 1'b0;
            rx_data_nxt   = rx_buf;
          end
          if (toggles == T_END && !cont) begin
            busy_nxt    = 1'b0;
            ss_n_nxt    = '1;
            mosi_oe_nxt = 1'b0;
            rx_data_nxt = rx_buf;
          end
        end else begin
          count_nxt = count + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      slave       <= '0;
      clk_ratio   <= '0;
      count       <= '0;
      assert_data <= 1'b0;
      tx_buf      <= '0;
      rx_buf      <= '0;
      toggles     <= '0;
      last_rx     <= '0;
      cont_pend   <= 1'b0;
      sclk        <= 1'b0;
      busy        <= 1'b1;
      ss_n        <= '1;
      mosi_q      <= 1'b0;
      mosi_oe     <= 1'b0;
      rx_data     <= '0;
    end else begin
      slave       <= slave_nxt;
      clk_ratio   <= clk_ratio_nxt;
      count       <= count_nxt;
      assert_data <= assert_data_nxt;
      tx_buf      <= tx_buf_nxt;
      rx_buf      <= rx_buf_nxt;
      toggles     <= toggles_nxt;
      last_rx     <= last_rx_nxt;
      cont_pend   <= cont_pend_nxt;
      sclk        <= sclk_nxt;
      busy        <= busy_nxt;
      ss_n        <= ss_n_nxt;
      mosi_q      <= mosi_q_nxt;
      mosi_oe     <= mosi_oe_nxt;
      rx_data     <= rx_data_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core (SLAVES=4, D_WIDTH=8): modes, divider,
// addressing, continuous words, ignored enable and mid-transfer reset.
module tb_spi_master_core;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        cont = 1'b0;
  logic [31:0] clk_div = 32'd0;
  logic [31:0] addr = 32'd0;
  logic [7:0]  tx_data = 8'h00;
  logic        miso;
  logic        sclk;
  logic [3:0]  ss_n;
  wire         mosi;
  logic        busy;
  logic [7:0]  rx_data;

  logic        loop_en = 1'b0;
  logic        miso_val = 1'b0;
  int          total = 0;
  int          bad = 0;

  int          busy_cnt, edges, ivl_min, ivl_max;
  logic [7:0]  cap;
  logic [3:0]  ss_and;
  logic        sclk_start, timed_out;

  int          pulse_c, end_c;
  logic [7:0]  pulse_rx;
  logic [3:0]  pulse_ss;
  logic        ss_break, after_pulse;

  assign miso = loop_en ? mosi : miso_val;

  spi_master_core #(.SLAVES(4), .D_WIDTH(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .cpol    (cpol),
    .cpha    (cpha),
    .cont    (cont),
    .clk_div (clk_div),
    .addr    (addr),
    .tx_data (tx_data),
    .miso    (miso),
    .sclk    (sclk),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .busy    (busy),
    .rx_data (rx_data)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer with cont=0; mosi is captured on the edges the slave samples.
  task automatic run_xfer(input logic [7:0] data, input logic pol, input logic pha,
                          input logic [31:0] div, input logic [31:0] a, input int poke);
    int   last_c;
    logic prev;
    logic done;
    tx_data = data; cpol = pol; cpha = pha; clk_div = div; addr = a; enable = 1'b1;
    step();
    enable = 1'b0;
    sclk_start = sclk;
    prev = sclk;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    edges = 0; cap = '0; ss_and = ss_n;
    ivl_min = 1000; ivl_max = 0; last_c = 0; done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      enable = (c == poke);
      step();
      if (sclk !== prev) begin
        edges++;
        if (edges > 1) begin
          if (c - last_c < ivl_min) ivl_min = c - last_c;
          if (c - last_c > ivl_max) ivl_max = c - last_c;
        end
        last_c = c;
        prev = sclk;
        if (edges[0] != pha) cap = {cap[6:0], mosi};
      end
      ss_and = ss_and & ss_n;
      if (busy === 1'b1) busy_cnt++;
      else done = 1'b1;
    end
    enable = 1'b0;
    timed_out = !done;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_busy", busy, 1);
    chk("rst_ss_n", ss_n, 4'hF);
    chk("rst_sclk", sclk, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_mosi_hiz", dut.mosi_oe, 0);
    reset_n = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // mode 0, clk_div 0, loopback
    loop_en = 1'b1;
    run_xfer(8'hA5, 1'b0, 1'b0, 32'd0, 32'd0, -1);
    chk("m0_timeout", timed_out, 0);
    chk("m0_busy_cycles", busy_cnt, 18);
    chk("m0_edges", edges, 16);
    chk("m0_mosi_bits", cap, 8'hA5);
    chk("m0_rx", rx_data, 8'hA5);
    chk("m0_ss_sel", ss_and, 4'b1110);
    chk("m0_ss_end", ss_n, 4'hF);
    chk("m0_sclk_end", sclk, 0);
    chk("m0_mosi_hiz", dut.mosi_oe, 0);
    step();
    chk("m0_busy_after", busy, 0);

    // mode 3, clk_div 4, miso held high
    loop_en = 1'b0; miso_val = 1'b1;
    run_xfer(8'h3C, 1'b1, 1'b1, 32'd4, 32'd0, -1);
    chk("m3_timeout", timed_out, 0);
    chk("m3_sclk_idle", sclk_start, 1);
    chk("m3_busy_cycles", busy_cnt, 69);
    chk("m3_edges", edges, 16);
    chk("m3_half_min", ivl_min, 4);
    chk("m3_half_max", ivl_max, 4);
    chk("m3_mosi_bits", cap, 8'h3C);
    chk("m3_rx", rx_data, 8'hFF);
    chk("m3_sclk_end", sclk, 1);

    // mode 1, addr 2, loopback
    loop_en = 1'b1;
    run_xfer(8'h96, 1'b0, 1'b1, 32'd1, 32'd2, -1);
    chk("a2_timeout", timed_out, 0);
    chk("a2_ss_sel", ss_and, 4'b1011);
    chk("a2_busy_cycles", busy_cnt, 18);
    chk("a2_rx", rx_data, 8'h96);
    chk("a2_mosi_bits", cap, 8'h96);

    // mode 2, addr 7 (out of range -> slave 0), clk_div 2
    run_xfer(8'h5A, 1'b1, 1'b0, 32'd2, 32'd7, -1);
    chk("a7_timeout", timed_out, 0);
    chk("a7_ss_sel", ss_and, 4'b1110);
    chk("a7_busy_cycles", busy_cnt, 35);
    chk("a7_rx", rx_data, 8'h5A);
    chk("a7_sclk_end", sclk, 1);

    // enable pulsed during EXECUTE is ignored
    run_xfer(8'hC3, 1'b0, 1'b0, 32'd0, 32'd0, 5);
    chk("en_timeout", timed_out, 0);
    chk("en_busy_cycles", busy_cnt, 18);
    chk("en_edges", edges, 16);
    chk("en_rx", rx_data, 8'hC3);
    step();
    step();
    chk("en_stays_idle", busy, 0);

    // continuous: 0x12 then 0x34
    cpol = 1'b0; cpha = 1'b0; clk_div = 32'd0; addr = 32'd0;
    cont = 1'b1; tx_data = 8'h12; enable = 1'b1;
    step();
    enable = 1'b0; tx_data = 8'h34;
    pulse_c = -1; end_c = -1; ss_break = 1'b0; after_pulse = 1'b0;
    pulse_rx = '0; pulse_ss = '0;
    for (int c = 0; c < 500 && end_c < 0; c++) begin
      step();
      if (pulse_c >= 0 && c == pulse_c + 1) after_pulse = busy;
      if (busy !== 1'b1) begin
        if (pulse_c < 0) begin
          pulse_c = c; pulse_rx = rx_data; pulse_ss = ss_n; cont = 1'b0;
        end else begin
          end_c = c;
        end
      end else if (ss_n[0] !== 1'b0) begin
        ss_break = 1'b1;
      end
    end
    cont = 1'b0;
    chk("cont_pulse_at", pulse_c, 16);
    chk("cont_pulse_rx", pulse_rx, 8'h12);
    chk("cont_pulse_ss", pulse_ss, 4'b1110);
    chk("cont_pulse_width", after_pulse, 1);
    chk("cont_ss_held", ss_break, 0);
    chk("cont_end_at", end_c, 33);
    chk("cont_final_rx", rx_data, 8'h34);
    chk("cont_ss_end", ss_n, 4'hF);

    // reset in the middle of a mode-3 word
    loop_en = 1'b0; miso_val = 1'b1;
    cpol = 1'b1; cpha = 1'b1; clk_div = 32'd2; addr = 32'd0; tx_data = 8'hF0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("mid_busy", busy, 1);
    chk("mid_ss", ss_n, 4'b1110);
    reset_n = 1'b1;
    #2;
    chk("mrst_busy", busy, 1);
    chk("mrst_ss", ss_n, 4'hF);
    chk("mrst_rx", rx_data, 0);
    chk("mrst_sclk", sclk, 0);
    chk("mrst_mosi_hiz", dut.mosi_oe, 0);
    reset_n = 1'b0;
    step();
    chk("mrst_release_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
